// File: rtl/idm_arbiter.sv
// Shares the single-ported unified instruction/data memory between fetch and load/store.
// Data wins ties, but a saturating streak counter hands the port to a waiting fetch.
module idm_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_func,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_func,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [2:0] FUNC_WORD = 3'b010;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              owner_is_d_q, owner_is_d_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]        mem_func_q, mem_func_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ack_q, i_ack_d, i_err_q, i_err_d;
  logic              d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  logic i_mask, d_mask, i_valid, d_valid, grant_i, grant_d;
  logic i_misaligned, d_misaligned;

  always_comb begin
    // A requester is invisible while its own access is on the port and during its ack.
    i_mask  = ((state_q == ACCESS) && !owner_is_d_q) || i_ack_q;
    d_mask  = ((state_q == ACCESS) && owner_is_d_q) || d_ack_q;
    i_valid = i_req && !i_mask;
    d_valid = d_req && !d_mask;
    grant_d = d_valid && !(i_valid && (streak_q == STREAK_MAX));
    grant_i = i_valid && !grant_d;

    i_misaligned = (i_addr[1:0] != 2'b00);
    case (d_func)
      3'b001, 3'b101: d_misaligned = d_addr[0];
      3'b010:         d_misaligned = (d_addr[1:0] != 2'b00);
      default:        d_misaligned = 1'b0;
    endcase

    state_d      = IDLE;
    owner_is_d_d = owner_is_d_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = '0;
    mem_func_d   = '0;
    mem_wdata_d  = '0;
    i_ack_d      = 1'b0;
    i_err_d      = 1'b0;
    d_ack_d      = 1'b0;
    d_err_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    if (state_q == ACCESS) begin
      if (owner_is_d_q) begin
        d_ack_d = 1'b1;
        if (!mem_write_q) d_rdata_d = mem_rdata;
      end else begin
        i_ack_d   = 1'b1;
        i_rdata_d = mem_rdata;
      end
    end

    if (grant_d) begin
      if (d_misaligned) begin
        d_ack_d = 1'b1;
        d_err_d = 1'b1;
      end else begin
        state_d      = ACCESS;
        owner_is_d_d = 1'b1;
        mem_read_d   = !d_we;
        mem_write_d  = d_we;
        mem_addr_d   = d_addr;
        mem_func_d   = d_func;
        mem_wdata_d  = d_wdata;
      end
    end else if (grant_i) begin
      if (i_misaligned) begin
        i_ack_d = 1'b1;
        i_err_d = 1'b1;
      end else begin
        state_d      = ACCESS;
        owner_is_d_d = 1'b0;
        mem_read_d   = 1'b1;
        mem_addr_d   = i_addr;
        mem_func_d   = FUNC_WORD;
      end
    end

    // Streak counts data grants that happen while fetch is asking for the port.
    if (!i_req || grant_i) streak_d = '0;
    else if (grant_d && (streak_q != STREAK_MAX)) streak_d = streak_q + 1'b1;
    else streak_d = streak_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_is_d_q <= 1'b0;
      streak_q     <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_func_q   <= '0;
      mem_wdata_q  <= '0;
      i_ack_q      <= 1'b0;
      i_err_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_is_d_q <= owner_is_d_d;
      streak_q     <= streak_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_func_q   <= mem_func_d;
      mem_wdata_q  <= mem_wdata_d;
      i_ack_q      <= i_ack_d;
      i_err_q      <= i_err_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_func  = mem_func_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
endmodule
